// File: rtl/fpu_pkg.sv
// Shared encodings, constants and result type for the FP sign-injection/compare pipe.
// Min/max encodings are only consumed when FPU_MINMAX_EN is defined.
package fpu_pkg;

    localparam logic [6:0] F7_SGNJ   = 7'h10;
    localparam logic [6:0] F7_CMP    = 7'h50;
    localparam logic [6:0] F7_MINMAX = 7'h14;

    localparam logic [2:0] F3_FSGNJ  = 3'd0;
    localparam logic [2:0] F3_FSGNJN = 3'd1;
    localparam logic [2:0] F3_FSGNJX = 3'd2;
    localparam logic [2:0] F3_FLE    = 3'd0;
    localparam logic [2:0] F3_FLT    = 3'd1;
    localparam logic [2:0] F3_FEQ    = 3'd2;
    localparam logic [2:0] F3_FMIN   = 3'd0;
    localparam logic [2:0] F3_FMAX   = 3'd1;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] y;
        logic        nv;
        logic        ill;
    } fpu_res_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

endpackage

// File: rtl/fpu_misc_core.sv
// Combinational decode/classify/compute for sign-injection, compare and min/max.
// Min/max datapath is built only when FPU_MINMAX_EN is defined; otherwise funct7 0x14 is illegal.
module fpu_misc_core
    import fpu_pkg::*;
(
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output fpu_res_t    res
);

    logic nan1, nan2, snan1, snan2, any_nan, both_zero, eq, lt_ord, lt;

    assign nan1      = is_nan(x1);
    assign nan2      = is_nan(x2);
    assign snan1     = is_snan(x1);
    assign snan2     = is_snan(x2);
    assign any_nan   = nan1 || nan2;
    assign both_zero = ~|{x1[30:0], x2[30:0]};
    assign eq        = (x1 == x2) || both_zero;

    // Sign-magnitude total order on non-NaNs; treats -0 < +0, which compares must undo.
    assign lt_ord = (x1[31] != x2[31]) ? x1[31] :
                    x1[31] ? (x1[30:0] > x2[30:0]) : (x1[30:0] < x2[30:0]);
    assign lt     = lt_ord && !both_zero;

`ifdef FPU_MINMAX_EN
    logic [31:0] mm;

    always_comb begin
        mm = x1;
        if (nan1 && nan2)
            mm = CANON_NAN;
        else if (nan1)
            mm = x2;
        else if (nan2)
            mm = x1;
        else
            mm = ((funct3 == F3_FMIN) == lt_ord) ? x1 : x2;
    end
`endif

    always_comb begin
        res = '0;
        case (funct7)
            F7_SGNJ: begin
                case (funct3)
                    F3_FSGNJ:  res.y = {x2[31], x1[30:0]};
                    F3_FSGNJN: res.y = {~x2[31], x1[30:0]};
                    F3_FSGNJX: res.y = {x1[31] ^ x2[31], x1[30:0]};
                    default:   res.ill = 1'b1;
                endcase
            end
            F7_CMP: begin
                case (funct3)
                    F3_FEQ: begin
                        res.y[0] = !any_nan && eq;
                        res.nv   = snan1 || snan2;
                    end
                    F3_FLT: begin
                        res.y[0] = !any_nan && lt;
                        res.nv   = any_nan;
                    end
                    F3_FLE: begin
                        res.y[0] = !any_nan && (lt || eq);
                        res.nv   = any_nan;
                    end
                    default: res.ill = 1'b1;
                endcase
            end
`ifdef FPU_MINMAX_EN
            F7_MINMAX: begin
                if (funct3 == F3_FMIN || funct3 == F3_FMAX) begin
                    res.y  = mm;
                    res.nv = snan1 || snan2;
                end else begin
                    res.ill = 1'b1;
                end
            end
`endif
            default: res.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_pipe.sv
// Elastic valid/ready pipeline around fpu_misc_core: result computed at entry, then shifted.
// fmin/fmax are available only when FPU_MINMAX_EN is defined.
module fpu_pipe
    import fpu_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv,
    output logic             out_ill
);

    fpu_res_t                     res_in;
    fpu_res_t [STAGES-1:0]        res_q, res_d;
    logic     [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic     [STAGES-1:0]        vld_pipe, vld_d, rdy;

    fpu_misc_core u_core (
        .funct7 (funct7),
        .funct3 (funct3),
        .x1     (x1),
        .x2     (x2),
        .res    (res_in)
    );

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // ready_k = !valid_k || ready_{k+1}, unrolled to avoid a combinational self-loop.
        assign rdy[k] = out_ready || !(&vld_pipe[STAGES-1:k]);
        if (k == 0) begin : g_head
            assign vld_d[k] = in_valid;
            assign res_d[k] = res_in;
            assign tag_d[k] = in_tag;
        end else begin : g_shift
            assign vld_d[k] = vld_pipe[k-1];
            assign res_d[k] = res_q[k-1];
            assign tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            res_q    <= '0;
            tag_q    <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_pipe[k] <= vld_d[k];
                    // Payload only moves with real data so bubbles leave it untouched.
                    if (vld_d[k]) begin
                        res_q[k] <= res_d[k];
                        tag_q[k] <= tag_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[STAGES-1];
    assign y         = res_q[STAGES-1].y;
    assign out_nv    = res_q[STAGES-1].nv;
    assign out_ill   = res_q[STAGES-1].ill;
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: doc/fpu_pipe.md
# fpu_pipe

Pipelined, handshaked successor to the single-cycle FP sign-injection/compare unit. Executes RV32F sign-injection, compare and (optionally) min/max on single-precision operands, with a parametrised number of elastic pipeline stages, a tag passed through with each operation, and IEEE invalid/illegal flags. Sits between the core's FP issue logic and the FP writeback arbiter. Accepts one operation per cycle under valid/ready backpressure.

## Interface
- STAGES, 2, number of register stages; legal range 1..4.
- TAG_W, 5, width of the pass-through tag, normally the destination register index.
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation present.
- in_ready  output  1  unit can accept this cycle.
- funct7  input  7  operation class.
- funct3  input  3  operation select within class.
- x1, x2  input  32  operands, IEEE-754 binary32.
- in_tag  input  TAG_W  tag captured with the operation.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts this cycle.
- y  output  32  result.
- out_tag  output  TAG_W  tag of the result.
- out_nv  output  1  IEEE invalid-operation flag for this result.
- out_ill  output  1  unsupported funct7/funct3 encoding.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Sign injection, funct7 = 0x10:
  - funct3 0, fsgnj: y = {x2[31], x1[30:0]}.
  - funct3 1, fsgnjn: y = {~x2[31], x1[30:0]}.
  - funct3 2, fsgnjx: y = {x1[31]^x2[31], x1[30:0]}.
  - out_nv = 0.
- Compare, funct7 = 0x50. y = {31'b0, r}.
  - funct3 2, feq: r = 1 iff the operands are numerically equal. +0 == -0. Any NaN gives r = 0. out_nv = 1 only if an operand is a signalling NaN.
  - funct3 1, flt: r = 1 iff x1 < x2.
  - funct3 0, fle: r = 1 iff x1 <= x2.
  - flt/fle: any NaN gives r = 0 and out_nv = 1. +0 and -0 compare equal.
- Min/max, funct7 = 0x14 (MINMAX feature only):
  - funct3 0 = fmin, funct3 1 = fmax.
  - -0 < +0 for ordering.
  - One NaN operand: y = the other operand.
  - Both operands NaN: y = 0x7FC00000, the canonical NaN.
  - out_nv = 1 if either operand is a signalling NaN.
- Classification:
  - NaN: exponent all-ones and mantissa nonzero.
  - Signalling NaN: a NaN with mantissa bit 22 = 0.
- Any other encoding, including funct3 3..7 in a legal class: y = 0, out_nv = 0, out_ill = 1, and the operation still flows and completes normally.

## Timing
- Result is computed combinationally from the inputs and captured into stage 0. Stages 1..STAGES-1 only shift.
- Stage k holds valid_k plus {y, tag, nv, ill}.
- Stage k loads when ready_k = !valid_k || ready_{k+1}. ready_STAGES = out_ready.
- in_ready = ready_0, and does not combinationally depend on in_valid.
- Latency is exactly STAGES cycles from accept to out_valid when out_ready is held high. Throughput is 1 op/cycle.
- Backpressure:
  - With out_ready low, the pipe fills. in_ready falls once all STAGES slots hold valid data.
  - No operation is dropped or duplicated.
  - Output payload is stable while out_valid && !out_ready.
- Full pipe: if out_ready is high in the same cycle as in_valid, the input is accepted in that cycle (simultaneous drain and fill).
- Reset: every valid_k = 0 and all payload registers = 0. Hence out_valid = 0, y = 0, out_tag = 0, out_nv = 0, out_ill = 0.
  - Reset mid-operation discards all in-flight operations.
  - in_ready is 1 from the first cycle after rstn deasserts.

## Configuration
- FPU_MINMAX_EN defined: fmin/fmax (funct7 0x14) are implemented as specified.
- FPU_MINMAX_EN undefined: no min/max logic is built, and funct7 0x14 is treated as illegal (y = 0, out_ill = 1).

## Structure
- Shared package fpu_pkg holds:
  - funct7 constants F7_SGNJ = 0x10, F7_CMP = 0x50, F7_MINMAX = 0x14.
  - funct3 constants for each operation.
  - CANON_NAN = 0x7FC00000.
  - A result struct {y, nv, ill}.
- Sub-module fpu_misc_core: purely combinational decode, classify and compute, producing the result struct.
- fpu_pipe holds the elastic stage registers and handshake logic only.

## Test plan
- STAGES=2, fsgnjn with x1=0x3F800000, x2=0x00000000, out_ready=1 -> y=0xBF800000 exactly 2 cycles after accept, out_tag = in_tag.
- feq with +0 (0x00000000) and -0 (0x80000000) -> y=1, out_nv=0.
- flt with x1=0x7FC00000 (qNaN), x2=0x3F800000 -> y=0, out_nv=1.
- feq with x1=0x7F800001 (sNaN), x2 anything -> y=0, out_nv=1.
- Backpressure: 6 back-to-back ops with out_ready=0 for 5 cycles:
  - in_ready falls after STAGES accepts.
  - After release, all results appear in order with correct tags.
  - No bubble while both valid and ready are high.
- fmin with x1=0x80000000, x2=0x00000000 -> y=0x80000000 under FPU_MINMAX_EN, out_ill=1 without it.
- funct7=0x50 with funct3=3 -> out_ill=1, y=0.
- Assert rstn low with a full pipe -> out_valid=0 immediately, and no stale result appears after release.
